// File: rtl/run_ctrl_if.sv
// Launch/halt handshake between the host-side driver and the run controller.
// The timeout signal exists only when RUN_CTRL_WATCHDOG_EN is defined.
interface run_ctrl_if #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
);
  logic             start;
  logic [PC_W-1:0]  start_addr;
  logic             halt_instr;
  logic             run;
  logic             pc_load;
  logic [PC_W-1:0]  pc_init;
  logic             halt;
  logic             done;
  logic [CNT_W-1:0] InstrCount;
`ifdef RUN_CTRL_WATCHDOG_EN
  logic             timeout;

  modport master (
    output start, start_addr, halt_instr,
    input  run, pc_load, pc_init, halt, done, InstrCount, timeout
  );

  modport slave (
    input  start, start_addr, halt_instr,
    output run, pc_load, pc_init, halt, done, InstrCount, timeout
  );
`else
  modport master (
    output start, start_addr, halt_instr,
    input  run, pc_load, pc_init, halt, done, InstrCount
  );

  modport slave (
    input  start, start_addr, halt_instr,
    output run, pc_load, pc_init, halt, done, InstrCount
  );
`endif
endinterface

// File: rtl/run_ctrl.sv
// Start/halt run controller: holds the core until launched, loads the PC and
// counts executed instructions. Define RUN_CTRL_WATCHDOG_EN for the count watchdog.
module run_ctrl #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input logic        CLK,
  input logic        Reset,
  run_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_next;
  logic             run_q;
  logic             pc_load_q;
  logic [PC_W-1:0]  pc_init_q;
  logic             halt_q;
  logic             done_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_inc;

  // Saturating increment: the count pins at all-ones instead of wrapping.
  assign count_inc = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;

`ifdef RUN_CTRL_WATCHDOG_EN
  logic timeout_q;
  logic wd_trip;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
`ifdef RUN_CTRL_WATCHDOG_EN
    wd_trip    = 1'b0;
`endif
    case (state)
      IDLE, DONE: if (bus.start) state_next = LOAD;
      LOAD:       if (!bus.start) state_next = RUN;
      RUN: begin
        // A relaunch wins over a coincident HALT.
        if (bus.start) begin
          state_next = LOAD;
        end else if (bus.halt_instr) begin
          state_next = DONE;
`ifdef RUN_CTRL_WATCHDOG_EN
        end else if (count_inc == CNT_MAX) begin
          state_next = DONE;
          wd_trip    = 1'b1;
`endif
        end
      end
      default:    state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet line
  // up with the state they describe.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      run_q     <= 1'b0;
      pc_load_q <= 1'b0;
      pc_init_q <= '0;
      halt_q    <= 1'b1;
      done_q    <= 1'b0;
      count_q   <= '0;
`ifdef RUN_CTRL_WATCHDOG_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      run_q     <= (state_next == RUN);
      pc_load_q <= (state_next == LOAD);
      halt_q    <= (state_next != RUN);
      done_q    <= (state_next == DONE);

      // Entering or staying in LOAD always means start is high: re-latch the
      // address so the last one before deassertion wins, and restart the count.
      if (state_next == LOAD) begin
        pc_init_q <= bus.start_addr;
        count_q   <= '0;
      end else if (state == RUN) begin
        count_q   <= count_inc;
      end

`ifdef RUN_CTRL_WATCHDOG_EN
      if (state_next == LOAD) begin
        timeout_q <= 1'b0;
      end else if (wd_trip) begin
        timeout_q <= 1'b1;
      end
`endif
    end
  end

  assign bus.run        = run_q;
  assign bus.pc_load    = pc_load_q;
  assign bus.pc_init    = pc_init_q;
  assign bus.halt       = halt_q;
  assign bus.done       = done_q;
  assign bus.InstrCount = count_q;
`ifdef RUN_CTRL_WATCHDOG_EN
  assign bus.timeout    = timeout_q;
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: a default instance for the launch/halt protocol
// and a CNT_W=4 instance for count saturation and the optional watchdog.
module tb_run_ctrl;

  logic CLK = 1'b0;
  logic Reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 CLK = ~CLK;

  run_ctrl_if #(.PC_W(8), .CNT_W(16)) b ();
  run_ctrl_if #(.PC_W(8), .CNT_W(4))  s ();

  run_ctrl #(.PC_W(8), .CNT_W(16)) u_dut   (.CLK(CLK), .Reset(Reset), .bus(b));
  run_ctrl #(.PC_W(8), .CNT_W(4))  u_small (.CLK(CLK), .Reset(Reset), .bus(s));

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_reset();
    step();
    n_tests++; if (b.run !== 1'b0) begin n_fail++; $display("FAIL rst_run got=%b want=0", b.run); end
    n_tests++; if (b.pc_load !== 1'b0) begin n_fail++; $display("FAIL rst_pc_load got=%b want=0", b.pc_load); end
    n_tests++; if (b.pc_init !== 8'd0) begin n_fail++; $display("FAIL rst_pc_init got=%0d want=0", b.pc_init); end
    n_tests++; if (b.halt !== 1'b1) begin n_fail++; $display("FAIL rst_halt got=%b want=1", b.halt); end
    n_tests++; if (b.done !== 1'b0) begin n_fail++; $display("FAIL rst_done got=%b want=0", b.done); end
    n_tests++; if (b.InstrCount !== 16'd0) begin n_fail++; $display("FAIL rst_count got=%0d want=0", b.InstrCount); end
    Reset = 1'b0;
    step(2);
    n_tests++; if (b.halt !== 1'b1 || b.run !== 1'b0) begin n_fail++; $display("FAIL idle_hold halt=%b run=%b want halt=1 run=0", b.halt, b.run); end
  endtask

  // One-cycle start at 75, HALT on the 10th RUN cycle.
  task automatic test_launch_halt();
    b.start = 1'b1; b.start_addr = 8'd75;
    step();
    n_tests++; if (b.pc_load !== 1'b1 || b.run !== 1'b0 || b.halt !== 1'b1) begin n_fail++; $display("FAIL lh_load pc_load=%b run=%b halt=%b want 1/0/1", b.pc_load, b.run, b.halt); end
    n_tests++; if (b.pc_init !== 8'd75) begin n_fail++; $display("FAIL lh_pc_init got=%0d want=75", b.pc_init); end
    b.start = 1'b0; b.start_addr = 8'd200;
    step();
    n_tests++; if (b.run !== 1'b1 || b.pc_load !== 1'b0 || b.halt !== 1'b0) begin n_fail++; $display("FAIL lh_run run=%b pc_load=%b halt=%b want 1/0/0", b.run, b.pc_load, b.halt); end
    n_tests++; if (b.pc_init !== 8'd75) begin n_fail++; $display("FAIL lh_pc_init_hold got=%0d want=75", b.pc_init); end
    step(9);
    n_tests++; if (b.InstrCount !== 16'd9 || b.run !== 1'b1) begin n_fail++; $display("FAIL lh_mid count=%0d run=%b want 9/1", b.InstrCount, b.run); end
    b.halt_instr = 1'b1;
    step();
    b.halt_instr = 1'b0;
    n_tests++; if (b.run !== 1'b0 || b.halt !== 1'b1 || b.done !== 1'b1) begin n_fail++; $display("FAIL lh_done run=%b halt=%b done=%b want 0/1/1", b.run, b.halt, b.done); end
    n_tests++; if (b.InstrCount !== 16'd10) begin n_fail++; $display("FAIL lh_count got=%0d want=10", b.InstrCount); end
    step(3);
    n_tests++; if (b.done !== 1'b1 || b.InstrCount !== 16'd10) begin n_fail++; $display("FAIL lh_sticky done=%b count=%0d want 1/10", b.done, b.InstrCount); end
  endtask

  // Start held three cycles with the address moving 0 -> 17 -> 127.
  task automatic test_long_start();
    logic [7:0] addrs [3];
    addrs[0] = 8'd0; addrs[1] = 8'd17; addrs[2] = 8'd127;
    b.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b.start_addr = addrs[i];
      step();
      n_tests++; if (b.pc_load !== 1'b1 || b.run !== 1'b0 || b.done !== 1'b0) begin n_fail++; $display("FAIL ls_load%0d pc_load=%b run=%b done=%b want 1/0/0", i, b.pc_load, b.run, b.done); end
      n_tests++; if (b.pc_init !== addrs[i]) begin n_fail++; $display("FAIL ls_addr%0d got=%0d want=%0d", i, b.pc_init, addrs[i]); end
    end
    b.start = 1'b0; b.start_addr = 8'd5;
    step();
    n_tests++; if (b.run !== 1'b1 || b.pc_load !== 1'b0 || b.pc_init !== 8'd127) begin n_fail++; $display("FAIL ls_run run=%b pc_load=%b pc_init=%0d want 1/0/127", b.run, b.pc_load, b.pc_init); end
    n_tests++; if (b.InstrCount !== 16'd0) begin n_fail++; $display("FAIL ls_count got=%0d want=0", b.InstrCount); end
  endtask

  // Enters in RUN cycle 1; start and HALT together on RUN cycle 5.
  task automatic test_restart_priority();
    step(4);
    n_tests++; if (b.InstrCount !== 16'd4) begin n_fail++; $display("FAIL rp_pre got=%0d want=4", b.InstrCount); end
    b.start = 1'b1; b.halt_instr = 1'b1; b.start_addr = 8'd33;
    step();
    b.start = 1'b0; b.halt_instr = 1'b0;
    n_tests++; if (b.pc_load !== 1'b1 || b.run !== 1'b0 || b.done !== 1'b0) begin n_fail++; $display("FAIL rp_load pc_load=%b run=%b done=%b want 1/0/0", b.pc_load, b.run, b.done); end
    n_tests++; if (b.InstrCount !== 16'd0 || b.pc_init !== 8'd33) begin n_fail++; $display("FAIL rp_clear count=%0d pc_init=%0d want 0/33", b.InstrCount, b.pc_init); end
    step();
    n_tests++; if (b.run !== 1'b1 || b.done !== 1'b0) begin n_fail++; $display("FAIL rp_run run=%b done=%b want 1/0", b.run, b.done); end
  endtask

  // Halt at RUN cycle 1, relaunch from DONE at 0, halt at RUN cycle 1 again.
  task automatic test_relaunch();
    b.halt_instr = 1'b1;
    step();
    b.halt_instr = 1'b0;
    n_tests++; if (b.done !== 1'b1 || b.InstrCount !== 16'd1) begin n_fail++; $display("FAIL rl_first done=%b count=%0d want 1/1", b.done, b.InstrCount); end
    b.start = 1'b1; b.start_addr = 8'd0;
    step();
    b.start = 1'b0;
    n_tests++; if (b.done !== 1'b0 || b.pc_load !== 1'b1 || b.pc_init !== 8'd0 || b.InstrCount !== 16'd0) begin n_fail++; $display("FAIL rl_load done=%b pc_load=%b pc_init=%0d count=%0d want 0/1/0/0", b.done, b.pc_load, b.pc_init, b.InstrCount); end
    step();
    b.halt_instr = 1'b1;
    step();
    n_tests++; if (b.done !== 1'b1 || b.run !== 1'b0 || b.InstrCount !== 16'd1) begin n_fail++; $display("FAIL rl_done done=%b run=%b count=%0d want 1/0/1", b.done, b.run, b.InstrCount); end
    // HALT flag keeps asserting in DONE; it must have no effect there.
    step(2);
    b.halt_instr = 1'b0;
    n_tests++; if (b.done !== 1'b1 || b.InstrCount !== 16'd1) begin n_fail++; $display("FAIL rl_ignore done=%b count=%0d want 1/1", b.done, b.InstrCount); end
  endtask

  task automatic test_reset_midrun();
    b.start = 1'b1; b.start_addr = 8'd9;
    step();
    b.start = 1'b0;
    step(3);
    #3;
    Reset = 1'b1;
    #1;
    n_tests++; if (b.run !== 1'b0 || b.halt !== 1'b1 || b.done !== 1'b0) begin n_fail++; $display("FAIL mr_ctrl run=%b halt=%b done=%b want 0/1/0", b.run, b.halt, b.done); end
    n_tests++; if (b.InstrCount !== 16'd0 || b.pc_init !== 8'd0) begin n_fail++; $display("FAIL mr_regs count=%0d pc_init=%0d want 0/0", b.InstrCount, b.pc_init); end
    step();
    Reset = 1'b0;
    step();
    n_tests++; if (b.halt !== 1'b1 || b.run !== 1'b0) begin n_fail++; $display("FAIL mr_idle halt=%b run=%b want 1/0", b.halt, b.run); end
  endtask

  // CNT_W=4 instance runs without HALT.
  task automatic test_saturation();
    s.start = 1'b1; s.start_addr = 8'd3;
    step();
    s.start = 1'b0;
    step();
    n_tests++; if (s.run !== 1'b1 || s.InstrCount !== 4'd0) begin n_fail++; $display("FAIL sat_start run=%b count=%0d want 1/0", s.run, s.InstrCount); end
    step(14);
    n_tests++; if (s.run !== 1'b1 || s.InstrCount !== 4'd14) begin n_fail++; $display("FAIL sat_14 run=%b count=%0d want 1/14", s.run, s.InstrCount); end
    step();
`ifdef RUN_CTRL_WATCHDOG_EN
    n_tests++; if (s.timeout !== 1'b1 || s.done !== 1'b1 || s.run !== 1'b0) begin n_fail++; $display("FAIL wd_trip timeout=%b done=%b run=%b want 1/1/0", s.timeout, s.done, s.run); end
    n_tests++; if (s.InstrCount !== 4'd15) begin n_fail++; $display("FAIL wd_count got=%0d want=15", s.InstrCount); end
    s.start = 1'b1;
    step();
    s.start = 1'b0;
    n_tests++; if (s.timeout !== 1'b0 || s.done !== 1'b0 || s.InstrCount !== 4'd0) begin n_fail++; $display("FAIL wd_clear timeout=%b done=%b count=%0d want 0/0/0", s.timeout, s.done, s.InstrCount); end
`else
    n_tests++; if (s.run !== 1'b1 || s.done !== 1'b0 || s.InstrCount !== 4'd15) begin n_fail++; $display("FAIL sat_15 run=%b done=%b count=%0d want 1/0/15", s.run, s.done, s.InstrCount); end
    step(5);
    n_tests++; if (s.run !== 1'b1 || s.InstrCount !== 4'd15) begin n_fail++; $display("FAIL sat_hold run=%b count=%0d want 1/15", s.run, s.InstrCount); end
    s.halt_instr = 1'b1;
    step();
    s.halt_instr = 1'b0;
    n_tests++; if (s.done !== 1'b1 || s.InstrCount !== 4'd15) begin n_fail++; $display("FAIL sat_halt done=%b count=%0d want 1/15", s.done, s.InstrCount); end
`endif
  endtask

  initial begin
    Reset = 1'b1;
    b.start = 1'b0; b.start_addr = 8'd0; b.halt_instr = 1'b0;
    s.start = 1'b0; s.start_addr = 8'd0; s.halt_instr = 1'b0;
    test_reset();
    test_launch_halt();
    test_long_start();
    test_restart_priority();
    test_relaunch();
    test_reset_midrun();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Start/halt run controller inside `TopLevel`. It is the processor-side responder to the host's `start`/`start_addr` launch handshake. It holds the core stalled until launched, loads the program counter with the requested start address, and enables execution until the decoder flags a halt instruction. It then reports `halt`/`done` and exposes the dynamic instruction count (`InstrCount`) that the host bench reads at end of run.

## Interface
- `PC_W`, default 8: width of program counter and `start_addr`.
- `CNT_W`, default 16: width of `InstrCount`.

- `CLK`  in  1  system clock, rising-edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  host launch request; level, sampled on `CLK`.
- `start_addr`  in  PC_W  program entry address; valid whenever `start`=1.
- `halt_instr`  in  1  decoder flag: instruction executing this cycle is HALT.
- `run`  out  1  execution enable to PC, register file and data memory write.
- `pc_load`  out  1  PC loads `pc_init` this cycle (overrides increment/branch).
- `pc_init`  out  PC_W  latched entry address.
- `halt`  out  1  core stopped (not executing).
- `done`  out  1  program completed via HALT or timeout; sticky until next launch.
- `InstrCount`  out  CNT_W  dynamic instructions executed in current/last run.
- `timeout`  out  1  run ended by watchdog (present only with watchdog compiled in).

## Operation
- States: IDLE, LOAD, RUN, DONE. All outputs are registered and Moore-decoded from state plus holding registers.
- Reset, asynchronous: state=IDLE, `run`=0, `pc_load`=0, `pc_init`=0, `halt`=1, `done`=0, `InstrCount`=0, `timeout`=0.
- IDLE: `halt`=1, `done`=0. A sampled `start`=1 goes to LOAD, latches `pc_init`←`start_addr`, clears `InstrCount` and `timeout`.
- LOAD: `pc_load`=1, `run`=0, `halt`=1.
  - `start` still 1: stay in LOAD and re-latch `start_addr` each cycle, so the last address before deassertion wins.
  - `start`=0: go to RUN.
- RUN: `run`=1, `halt`=0. Each cycle in RUN adds 1 to `InstrCount`.
  - `halt_instr`=1: the HALT is counted, then go to DONE.
  - `start`=1 (in any cycle, including one where `halt_instr`=1): restart. Go to LOAD, latch the address, clear the count. `start` has priority over `halt_instr`.
- DONE: `run`=0, `halt`=1, `done`=1. `InstrCount` holds. `start`=1 relaunches exactly as from IDLE and clears `done`.
- `halt_instr` is ignored outside RUN.
- Count arithmetic is unsigned, CNT_W bits. It saturates at 2^CNT_W−1 and never wraps.

## Timing
- Launch latency: `start` sampled high at edge N gives `pc_load`=1 in cycle N. With `start` low at edge N+1, `run`=1 from cycle N+1, and the first instruction fetches from `pc_init`.
- Minimum `start` pulse is one clock. Longer pulses only extend LOAD.
- HALT sampled at edge M gives `run`=0, `halt`=1, `done`=1 from cycle M. The HALT instruction itself commits no further writes after edge M.
- `InstrCount` after a run equals the number of RUN cycles, HALT included.
- Asserting `Reset` mid-run aborts immediately, with no completion of the in-flight instruction. Outputs take reset values asynchronously.

## Configuration
- `RUN_CTRL_WATCHDOG_EN` defined:
  - Reaching `InstrCount`=2^CNT_W−1 in RUN without a HALT forces the next state to DONE with `timeout`=1 and `done`=1.
  - `timeout` clears on the next launch or on reset.
- Not defined:
  - No `timeout` port.
  - The count saturates and the core stays in RUN until HALT, `start` or `Reset`.

## Test plan
- Reset while RUN: assert `Reset` asynchronously → `run`=0, `halt`=1, `done`=0, `InstrCount`=0 immediately, without waiting for a clock edge.
- One-cycle `start` with `start_addr`=8'd75, then `halt_instr` pulsed on the 10th RUN cycle → `pc_load` for 1 cycle, `pc_init`=75, `done`=1, `InstrCount`=10.
- `start` held 3 cycles with `start_addr` changing 0→17→127 → 3 LOAD cycles, `pc_init`=127, RUN begins in the cycle after deassertion.
- `start`=1 on RUN cycle 5, coincident with `halt_instr`=1 → back to LOAD, `InstrCount`=0, `done` stays 0.
- Relaunch from DONE with `start_addr`=0 and HALT on RUN cycle 1 → `done` drops during LOAD, rises again, `InstrCount`=1.
- CNT_W=4 and no HALT:
  - With `RUN_CTRL_WATCHDOG_EN`: after 15 RUN cycles → `timeout`=1, `done`=1.
  - Without it: `InstrCount` holds at 15 and `run` stays 1.
